mp_adder_arbiter: RTL and testbench
===================================

Name: mp_adder_arbiter

Overview:
Round-robin arbiter that shares one mp_adder instance among NREQ independent requesters, for example several UART command front-ends or an on-chip self-test engine.
- Each requester presents operands and an add/sub select, then waits for its grant.
- The arbiter latches the winner's operands and drives the adder's start/done handshake.
- It returns the (OPERAND_WIDTH+1)-bit result with a per-requester done pulse.
- A watchdog aborts a transaction if the adder never reports done.

Parameters:
NREQ, 2, number of requesters (1..8).
OPERAND_WIDTH, 1024, operand width in bits; result is OPERAND_WIDTH+1.
TIMEOUT_CYCLES, 0, maximum BUSY cycles before abort; 0 disables the watchdog.

Ports:
iClk  in  1  clock; all logic is on the rising edge.
iRstN  in  1  asynchronous, active-low reset.
iReq  in  NREQ  level request per requester; held until that requester's oDone.
iOpA  in  NREQ*OPERAND_WIDTH  flattened operand A; slice k belongs to requester k.
iOpB  in  NREQ*OPERAND_WIDTH  flattened operand B.
iSub  in  NREQ  1 = A-B, 0 = A+B, per requester.
oGnt  out  NREQ  one-hot grant; high from latch until the done pulse.
oDone  out  NREQ  one-cycle pulse to the served requester.
oErr  out  1  high together with oDone when the transaction timed out.
oRes  out  OPERAND_WIDTH+1  last result; holds until the next completion.
oAddStart  out  1  one-cycle start to mp_adder.
oAddOpA  out  OPERAND_WIDTH  latched operand A to mp_adder.
oAddOpB  out  OPERAND_WIDTH  latched operand B to mp_adder.
oAddSub  out  1  latched subtract select to mp_adder.
iAddRes  in  OPERAND_WIDTH+1  mp_adder result.
iAddDone  in  1  mp_adder done pulse.

Behaviour:
- All outputs are registered.
- Reset (iRstN=0, asynchronous) clears: state to IDLE, round-robin pointer to 0, all outputs to 0, watchdog counter to 0.
- Reset mid-transaction abandons it. No oDone is issued.
- States: IDLE, BUSY, DONE.
- IDLE:
  - If any iReq bit is high, select the winner by round-robin. Search starts at pointer index and wraps at NREQ-1 to 0.
  - On that edge: oGnt <= onehot(winner); latch the winner's iOpA/iOpB/iSub into oAddOpA/oAddOpB/oAddSub; oAddStart <= 1; counter <= 0; go to BUSY.
  - If no request, stay in IDLE with outputs unchanged.
- BUSY:
  - oAddStart drops to 0 after exactly one cycle.
  - iAddDone is ignored during the cycle oAddStart is high; it is considered only from the following cycle.
  - On iAddDone: oRes <= iAddRes; oDone[winner] <= 1; oErr <= 0; go to DONE.
  - Else, if TIMEOUT_CYCLES > 0 and counter == TIMEOUT_CYCLES-1: oRes <= 0; oDone[winner] <= 1; oErr <= 1; go to DONE.
  - Otherwise counter increments; counter width is clog2(TIMEOUT_CYCLES+1), min 1.
- DONE (one cycle):
  - oDone, oErr, oGnt return to 0; pointer <= (winner+1) mod NREQ; go to IDLE.
  - iReq is not sampled in DONE.
- Latency: request seen at edge N gives oAddStart high in cycle N+1. Adder done at edge M gives oDone high in cycle M+1.
- Minimum back-to-back spacing between two grants is adder latency + 3 cycles.
- Fairness: a requester that keeps iReq high after its oDone is served again only after every other active requester has been served once.
- Operands and iSub of the granted requester may change after grant. Only the values latched at grant are used.
- Requests that deassert before grant are dropped silently.
- iAddDone arriving in IDLE or DONE is ignored.
- The oGnt bit for a requester whose iReq drops during BUSY stays high; the transaction completes normally.
- NREQ=1: arbitration is degenerate and the pointer stays 0.

Test Plan:
1. Single request, W=16, NREQ=2: req0 with A=0xFFFF, B=0x0001, sub=0; adder model latency 5. Expected: oAddStart one cycle; oRes=0x10000; oDone[0] pulses once; oGnt returns to 00.
2. Simultaneous req0 and req1 from reset: req0 add 0x1234+0x0001, req1 sub 0x0005-0x0007. Expected: req0 served first with oRes=0x01235; then req1 with oAddSub=1, and oRes equals model output 0x1FFFE.
3. Fairness: req0 and req1 held high for 6 transactions. Expected grant order 0,1,0,1,0,1.
4. Operand change after grant: alter iOpA[0] in the cycle after grant. Expected: oAddOpA keeps the latched value and the result matches the original operands.
5. Watchdog, TIMEOUT_CYCLES=10: adder never raises done. Expected: oDone[0] and oErr high in the same cycle, 11 cycles after grant; oRes=0; the next request is served normally.
6. Async reset: assert iRstN=0 mid-BUSY between clock edges. Expected: outputs clear immediately and no oDone appears. After release, a pending req1 is granted before req0 (pointer reset to 0 favours req0 only if requesting; here only req1 requests).

Source files
------------

// File: rtl/mp_adder_arbiter.sv
// Round-robin arbiter sharing one mp_adder among NREQ requesters.
// Latches the winner's operands, runs the start/done handshake and guards it with an optional watchdog.
module mp_adder_arbiter #(
    parameter int NREQ           = 2,
    parameter int OPERAND_WIDTH  = 1024,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                            iClk,
    input  logic                            iRstN,
    input  logic [NREQ-1:0]                 iReq,
    input  logic [NREQ*OPERAND_WIDTH-1:0]   iOpA,
    input  logic [NREQ*OPERAND_WIDTH-1:0]   iOpB,
    input  logic [NREQ-1:0]                 iSub,
    output logic [NREQ-1:0]                 oGnt,
    output logic [NREQ-1:0]                 oDone,
    output logic                            oErr,
    output logic [OPERAND_WIDTH:0]          oRes,
    output logic                            oAddStart,
    output logic [OPERAND_WIDTH-1:0]        oAddOpA,
    output logic [OPERAND_WIDTH-1:0]        oAddOpB,
    output logic                            oAddSub,
    input  logic [OPERAND_WIDTH:0]          iAddRes,
    input  logic                            iAddDone
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} stateT;

    stateT                   stateReg, stateNext;
    logic [IDX_W-1:0]        ptrReg, ptrNext;
    logic [IDX_W-1:0]        winnerReg, winnerNext;
    logic [CNT_W-1:0]        cntReg, cntNext;
    logic [NREQ-1:0]         gntReg, gntNext;
    logic [NREQ-1:0]         doneReg, doneNext;
    logic                    errReg, errNext;
    logic [OPERAND_WIDTH:0]  resReg, resNext;
    logic                    startReg, startNext;
    logic [OPERAND_WIDTH-1:0] opAReg, opANext;
    logic [OPERAND_WIDTH-1:0] opBReg, opBNext;
    logic                    subReg, subNext;

    logic [OPERAND_WIDTH-1:0] opAArr [NREQ];
    logic [OPERAND_WIDTH-1:0] opBArr [NREQ];

    logic                    found;
    logic [IDX_W-1:0]        winIdx;
    int                      scanIdx;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : genUnpack
            assign opAArr[gi] = iOpA[gi*OPERAND_WIDTH +: OPERAND_WIDTH];
            assign opBArr[gi] = iOpB[gi*OPERAND_WIDTH +: OPERAND_WIDTH];
        end
    endgenerate

    // First active request at or after the pointer, wrapping at NREQ-1.
    always_comb begin
        found   = 1'b0;
        winIdx  = '0;
        scanIdx = 0;
        for (int i = 0; i < NREQ; i++) begin
            scanIdx = (int'(ptrReg) + i) % NREQ;
            if (!found && iReq[scanIdx]) begin
                found  = 1'b1;
                winIdx = IDX_W'(scanIdx);
            end
        end
    end

    always_comb begin
        stateNext  = stateReg;
        ptrNext    = ptrReg;
        winnerNext = winnerReg;
        cntNext    = cntReg;
        gntNext    = gntReg;
        doneNext   = doneReg;
        errNext    = errReg;
        resNext    = resReg;
        startNext  = startReg;
        opANext    = opAReg;
        opBNext    = opBReg;
        subNext    = subReg;
        case (stateReg)
            IDLE: begin
                if (found) begin
                    winnerNext = winIdx;
                    gntNext    = NREQ'(1) << winIdx;
                    opANext    = opAArr[winIdx];
                    opBNext    = opBArr[winIdx];
                    subNext    = iSub[winIdx];
                    startNext  = 1'b1;
                    cntNext    = '0;
                    stateNext  = BUSY;
                end
            end
            BUSY: begin
                startNext = 1'b0;
                // The start cycle is excluded from both done detection and the watchdog count.
                if (!startReg) begin
                    if (iAddDone) begin
                        resNext   = iAddRes;
                        doneNext  = NREQ'(1) << winnerReg;
                        errNext   = 1'b0;
                        stateNext = DONE;
                    end else if (TIMEOUT_CYCLES > 0 && cntReg == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        resNext   = '0;
                        doneNext  = NREQ'(1) << winnerReg;
                        errNext   = 1'b1;
                        stateNext = DONE;
                    end else if (TIMEOUT_CYCLES > 0) begin
                        cntNext = cntReg + 1'b1;
                    end
                end
            end
            DONE: begin
                doneNext  = '0;
                errNext   = 1'b0;
                gntNext   = '0;
                if (NREQ == 1 || winnerReg == IDX_W'(NREQ - 1))
                    ptrNext = '0;
                else
                    ptrNext = winnerReg + 1'b1;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            stateReg  <= IDLE;
            ptrReg    <= '0;
            winnerReg <= '0;
            cntReg    <= '0;
            gntReg    <= '0;
            doneReg   <= '0;
            errReg    <= 1'b0;
            resReg    <= '0;
            startReg  <= 1'b0;
            opAReg    <= '0;
            opBReg    <= '0;
            subReg    <= 1'b0;
        end else begin
            stateReg  <= stateNext;
            ptrReg    <= ptrNext;
            winnerReg <= winnerNext;
            cntReg    <= cntNext;
            gntReg    <= gntNext;
            doneReg   <= doneNext;
            errReg    <= errNext;
            resReg    <= resNext;
            startReg  <= startNext;
            opAReg    <= opANext;
            opBReg    <= opBNext;
            subReg    <= subNext;
        end
    end

    assign oGnt      = gntReg;
    assign oDone     = doneReg;
    assign oErr      = errReg;
    assign oRes      = resReg;
    assign oAddStart = startReg;
    assign oAddOpA   = opAReg;
    assign oAddOpB   = opBReg;
    assign oAddSub   = subReg;

endmodule

// File: tb/tb_mp_adder_arbiter.sv
// Directed bench for mp_adder_arbiter: NREQ=2, 16-bit operands, watchdog of 10 cycles,
// with a fixed-latency adder model that can be silenced to provoke timeouts.
module tb_mp_adder_arbiter;

    localparam int W    = 16;
    localparam int NREQ = 2;

    logic            iClk;
    logic            iRstN;
    logic [NREQ-1:0] iReq;
    logic [NREQ*W-1:0] iOpA;
    logic [NREQ*W-1:0] iOpB;
    logic [NREQ-1:0] iSub;
    logic [NREQ-1:0] oGnt;
    logic [NREQ-1:0] oDone;
    logic            oErr;
    logic [W:0]      oRes;
    logic            oAddStart;
    logic [W-1:0]    oAddOpA;
    logic [W-1:0]    oAddOpB;
    logic            oAddSub;
    logic [W:0]      iAddRes;
    logic            iAddDone;

    int checks = 0;
    int errors = 0;
    int cycleCnt = 0;
    int gntCyc = 0;
    int doneCyc = 0;
    int prevGntCyc = 0;

    logic [3:0] modelCnt;
    logic       addEn;
    logic       spurious;

    mp_adder_arbiter #(
        .NREQ(NREQ), .OPERAND_WIDTH(W), .TIMEOUT_CYCLES(10)
    ) dut (
        .iClk(iClk), .iRstN(iRstN), .iReq(iReq), .iOpA(iOpA), .iOpB(iOpB), .iSub(iSub),
        .oGnt(oGnt), .oDone(oDone), .oErr(oErr), .oRes(oRes), .oAddStart(oAddStart),
        .oAddOpA(oAddOpA), .oAddOpB(oAddOpB), .oAddSub(oAddSub),
        .iAddRes(iAddRes), .iAddDone(iAddDone)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    always @(posedge iClk) cycleCnt <= cycleCnt + 1;

    // Adder model: done pulse five cycles after start is sampled.
    always @(posedge iClk or negedge iRstN) begin
        if (!iRstN)
            modelCnt <= '0;
        else if (oAddStart && addEn)
            modelCnt <= 4'd5;
        else if (modelCnt != 0)
            modelCnt <= modelCnt - 1'b1;
    end
    assign iAddDone = (modelCnt == 4'd1) | spurious;
    assign iAddRes  = oAddSub ? ({1'b0, oAddOpA} - {1'b0, oAddOpB})
                              : ({1'b0, oAddOpA} + {1'b0, oAddOpB});

    task automatic check(input string tag, input logic [W:0] obs, input logic [W:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic waitGnt(input logic [NREQ-1:0] exp, input string tag);
        int n = 0;
        while (oGnt == '0 && n < 30) begin
            @(negedge iClk);
            n++;
        end
        if (oGnt == '0) begin
            checks++;
            errors++;
            $error("FAIL %s: observed no grant expected %b", tag, exp);
        end else begin
            check(tag, {{(W+1-NREQ){1'b0}}, oGnt}, {{(W+1-NREQ){1'b0}}, exp});
        end
        prevGntCyc = gntCyc;
        gntCyc = cycleCnt;
    endtask

    task automatic waitDone(input string tag);
        int n = 0;
        while (oDone == '0 && n < 40) begin
            @(negedge iClk);
            n++;
        end
        doneCyc = cycleCnt;
        if (oDone == '0) begin
            checks++;
            errors++;
            $error("FAIL %s: observed no done expected a done pulse", tag);
        end
        $display("txn %s: gnt=%b done=%b err=%b res=%h latency=%0d",
                 tag, oGnt, oDone, oErr, oRes, doneCyc - gntCyc);
    endtask

    task automatic applyReset();
        iRstN = 1'b0;
        @(negedge iClk);
        @(negedge iClk);
        iRstN = 1'b1;
    endtask

    initial begin
        iRstN = 1'b0; iReq = '0; iOpA = '0; iOpB = '0; iSub = '0;
        addEn = 1'b1; spurious = 1'b0;
        #1;
        check("rst_gnt",   {15'd0, oGnt}, 17'd0);
        check("rst_done",  {15'd0, oDone}, 17'd0);
        check("rst_res",   oRes, 17'd0);
        check("rst_start", {16'd0, oAddStart}, 17'd0);
        @(negedge iClk);
        @(negedge iClk);
        iRstN = 1'b1;

        // 1: single add with carry out
        iReq = 2'b01; iOpA[15:0] = 16'hFFFF; iOpB[15:0] = 16'h0001; iSub[0] = 1'b0;
        waitGnt(2'b01, "t1_gnt");
        check("t1_start_hi", {16'd0, oAddStart}, 17'd1);
        @(negedge iClk);
        check("t1_start_lo", {16'd0, oAddStart}, 17'd0);
        check("t1_opa", {1'b0, oAddOpA}, 17'h0FFFF);
        waitDone("t1");
        check("t1_done", {15'd0, oDone}, 17'd1);
        check("t1_res", oRes, 17'h10000);
        check("t1_err", {16'd0, oErr}, 17'd0);
        check("t1_lat", 17'(doneCyc - gntCyc), 17'd6);
        iReq = 2'b00;
        @(negedge iClk);
        check("t1_done_drop", {15'd0, oDone}, 17'd0);
        check("t1_gnt_drop", {15'd0, oGnt}, 17'd0);

        // 2: simultaneous requests from reset
        applyReset();
        iOpA[15:0] = 16'h1234; iOpB[15:0] = 16'h0001; iSub[0] = 1'b0;
        iOpA[31:16] = 16'h0005; iOpB[31:16] = 16'h0007; iSub[1] = 1'b1;
        iReq = 2'b11;
        waitGnt(2'b01, "t2_gnt0");
        waitDone("t2_req0");
        check("t2_res0", oRes, 17'h01235);
        iReq = 2'b10;
        @(negedge iClk);
        waitGnt(2'b10, "t2_gnt1");
        check("t2_sub", {16'd0, oAddSub}, 17'd1);
        waitDone("t2_req1");
        check("t2_done1", {15'd0, oDone}, 17'd2);
        check("t2_res1", oRes, 17'h1FFFE);
        iReq = 2'b00;
        @(negedge iClk);

        // 3: fairness with both requests held
        iReq = 2'b11;
        for (int i = 0; i < 6; i++) begin
            waitGnt((i % 2 == 0) ? 2'b01 : 2'b10, $sformatf("t3_gnt%0d", i));
            if (i > 0) check("t3_spacing", 17'(gntCyc - prevGntCyc), 17'd8);
            waitDone($sformatf("t3_txn%0d", i));
            if (i == 5) iReq = 2'b00;
            @(negedge iClk);
        end

        // 4: operand change after grant
        iReq = 2'b01; iOpA[15:0] = 16'h00F0; iOpB[15:0] = 16'h000F; iSub[0] = 1'b0;
        waitGnt(2'b01, "t4_gnt");
        iOpA[15:0] = 16'hAAAA; iSub[0] = 1'b1;
        @(negedge iClk);
        check("t4_opa", {1'b0, oAddOpA}, 17'h000F0);
        check("t4_sub", {16'd0, oAddSub}, 17'd0);
        waitDone("t4");
        check("t4_res", oRes, 17'h000FF);
        iReq = 2'b00;
        @(negedge iClk);

        // 5: watchdog, adder silent
        addEn = 1'b0;
        iReq = 2'b01;
        waitGnt(2'b01, "t5_gnt");
        waitDone("t5_timeout");
        check("t5_done", {15'd0, oDone}, 17'd1);
        check("t5_err", {16'd0, oErr}, 17'd1);
        check("t5_res", oRes, 17'd0);
        check("t5_lat", 17'(doneCyc - gntCyc), 17'd11);
        iReq = 2'b00;
        addEn = 1'b1;
        @(negedge iClk);
        iReq = 2'b10; iOpA[31:16] = 16'h0010; iOpB[31:16] = 16'h0001; iSub[1] = 1'b1;
        waitGnt(2'b10, "t5_gnt_next");
        waitDone("t5_next");
        check("t5_next_res", oRes, 17'h0000F);
        check("t5_next_err", {16'd0, oErr}, 17'd0);
        iReq = 2'b00;
        @(negedge iClk);

        // stray adder done while idle
        spurious = 1'b1;
        @(negedge iClk);
        spurious = 1'b0;
        check("idle_done_ignored", {15'd0, oDone}, 17'd0);
        check("idle_res_hold", oRes, 17'h0000F);

        // 6: asynchronous reset mid-BUSY
        iReq = 2'b01; iOpA[15:0] = 16'h0001; iOpB[15:0] = 16'h0001; iSub[0] = 1'b0;
        waitGnt(2'b01, "t6_gnt");
        @(negedge iClk);
        #2 iRstN = 1'b0;
        #1;
        check("t6_gnt_clr", {15'd0, oGnt}, 17'd0);
        check("t6_opa_clr", {1'b0, oAddOpA}, 17'd0);
        check("t6_res_clr", oRes, 17'd0);
        iReq = 2'b10; iOpA[31:16] = 16'h0003; iOpB[31:16] = 16'h0004; iSub[1] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge iClk);
            check("t6_no_done", {15'd0, oDone}, 17'd0);
        end
        iRstN = 1'b1;
        waitGnt(2'b10, "t6_gnt_after");
        waitDone("t6_after");
        check("t6_done_after", {15'd0, oDone}, 17'd2);
        check("t6_res_after", oRes, 17'h00007);
        iReq = 2'b00;
        @(negedge iClk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
